// File: rtl/logic_gates_pkg.sv
// logic_gates_pkg: gate bit indices and checker state encoding shared by the gate checker files
package logic_gates_pkg;
    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_XOR  = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XNOR = 5;
    localparam int NUM_GATES = 6;
    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CHECK, ST_DONE} state_t;
endpackage

// File: rtl/logic_gate_ref.sv
// logic_gate_ref: golden truth table for the six two-input gates, in fail_mask bit order
module logic_gate_ref
    import logic_gates_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] y
);
    always_comb begin
        y            = '0;
        y[GATE_AND]  = a & b;
        y[GATE_OR]   = a | b;
        y[GATE_XOR]  = a ^ b;
        y[GATE_NAND] = ~(a & b);
        y[GATE_NOR]  = ~(a | b);
        y[GATE_XNOR] = ~(a ^ b);
    end
endmodule

// File: rtl/logic_gate_checker.sv
// logic_gate_checker: sweeps operands 00..11 through a gate bank and checks all six outputs.
// Optional saturating mismatch counter (err_count) enabled by LOGIC_GATE_CHK_ERRCNT_EN.
module logic_gate_checker
    import logic_gates_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
`ifdef LOGIC_GATE_CHK_ERRCNT_EN
    , parameter int ERR_W = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a_out,
    output logic                 b_out,
    input  logic                 and_in,
    input  logic                 or_in,
    input  logic                 xor_in,
    input  logic                 nand_in,
    input  logic                 nor_in,
    input  logic                 xnor_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] fail_mask,
    output logic [1:0]           first_fail_ab
`ifdef LOGIC_GATE_CHK_ERRCNT_EN
    , output logic [ERR_W-1:0]   err_count
`endif
);
    state_t               r_state;
    logic [1:0]           r_vec;
    logic [1:0]           r_ab;
    logic [7:0]           r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [NUM_GATES-1:0] r_mask;
    logic [1:0]           r_first;
    logic [NUM_GATES-1:0] w_exp;
    logic [NUM_GATES-1:0] w_got;
    logic [NUM_GATES-1:0] w_mis;
    logic [NUM_GATES-1:0] w_mask_nxt;
    logic                 w_settled;

    logic_gate_ref u_ref (
        .a(r_vec[1]),
        .b(r_vec[0]),
        .y(w_exp)
    );

    assign w_got      = {xnor_in, nor_in, nand_in, xor_in, or_in, and_in};
    assign w_mis      = w_got ^ w_exp;
    assign w_mask_nxt = r_mask | w_mis;
    assign w_settled  = r_cnt == 8'(SETTLE_CYCLES - 1);

`ifdef LOGIC_GATE_CHK_ERRCNT_EN
    logic [ERR_W-1:0] r_err;
    logic [ERR_W:0]   w_err_sum;
    assign w_err_sum = {1'b0, r_err} + (ERR_W + 1)'($countones(w_mis));
    assign err_count = r_err;
`endif

    // DONE doubles as an IDLE edge so a held start re-arms without a gap cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_ab    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_mask  <= '0;
            r_first <= '0;
`ifdef LOGIC_GATE_CHK_ERRCNT_EN
            r_err   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_DRIVE;
                        r_busy  <= 1'b1;
                        r_vec   <= '0;
                        r_ab    <= '0;
                        r_cnt   <= '0;
                        r_pass  <= 1'b0;
                        r_mask  <= '0;
                        r_first <= '0;
`ifdef LOGIC_GATE_CHK_ERRCNT_EN
                        r_err   <= '0;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    r_state <= w_settled ? ST_CHECK : ST_DRIVE;
                    r_cnt   <= w_settled ? '0 : r_cnt + 8'd1;
                end
                ST_CHECK: begin
                    r_mask <= w_mask_nxt;
                    if (r_mask == '0 && |w_mis)
                        r_first <= r_vec;
`ifdef LOGIC_GATE_CHK_ERRCNT_EN
                    r_err <= w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];
`endif
                    if (r_vec == 2'b11) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= w_mask_nxt == '0;
                        r_ab    <= '0;
                    end else begin
                        r_state <= ST_DRIVE;
                        r_vec   <= r_vec + 2'd1;
                        r_ab    <= r_vec + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign a_out         = r_ab[1];
    assign b_out         = r_ab[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign fail_mask     = r_mask;
    assign first_fail_ab = r_first;
endmodule

// File: tb/tb_logic_gate_checker.sv
// tb_logic_gate_checker: table-driven and randomized sweeps on two checkers (SETTLE_CYCLES 1 and 3).
// err_count is checked only when LOGIC_GATE_CHK_ERRCNT_EN is defined.
module tb_logic_gate_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_r [2];
    logic       a_o [2];
    logic       b_o [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [5:0] mask [2];
    logic [1:0] first [2];
    logic [5:0] g [2];
    logic       glitch [2];
    logic       glitch_en [2];
    int         mode [2];
    logic [5:0] corr [2][4];
`ifdef LOGIC_GATE_CHK_ERRCNT_EN
    logic [7:0] err [2];
`endif
    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    logic_gate_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_r[0]), .a_out(a_o[0]), .b_out(b_o[0]),
        .and_in(g[0][0]), .or_in(g[0][1]), .xor_in(g[0][2]), .nand_in(g[0][3]),
        .nor_in(g[0][4]), .xnor_in(g[0][5]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .fail_mask(mask[0]), .first_fail_ab(first[0])
`ifdef LOGIC_GATE_CHK_ERRCNT_EN
        , .err_count(err[0])
`endif
    );

    logic_gate_checker #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_r[1]), .a_out(a_o[1]), .b_out(b_o[1]),
        .and_in(g[1][0]), .or_in(g[1][1]), .xor_in(g[1][2]), .nand_in(g[1][3]),
        .nor_in(g[1][4]), .xnor_in(g[1][5]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .fail_mask(mask[1]), .first_fail_ab(first[1])
`ifdef LOGIC_GATE_CHK_ERRCNT_EN
        , .err_count(err[1])
`endif
    );

    // bits: [0]AND [1]OR [2]XOR [3]NAND [4]NOR [5]XNOR, from arithmetic on the operands
    function automatic logic [5:0] truth(input int a, input int b);
        int s = a + b;
        return {s % 2 == 0, s == 0, a * b == 0, s % 2 == 1, s > 0, a * b == 1};
    endfunction

    // gate bank under test: 1 XOR stuck-0, 2 NAND/NOR swapped, 3 random corruption, 4 AND stuck-1
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            g[w] = truth(int'(a_o[w]), int'(b_o[w]));
            if (mode[w] == 1) g[w][2] = 1'b0;
            if (mode[w] == 2) g[w][4:3] = {g[w][3], g[w][4]};
            if (mode[w] == 3) g[w] = g[w] ^ corr[w][{a_o[w], b_o[w]}];
            if (mode[w] == 4) g[w][0] = 1'b1;
            g[w][0] = g[w][0] ^ glitch[w];
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int w, input bit e_pass, input logic [5:0] e_mask,
                         input logic [1:0] e_first, input int e_err, input string tag);
        int s   = (w == 1) ? 3 : 1;
        int lat = 4 * (s + 1);
        int got = -1;
        start_r[w] = 1'b1;
        tick();
        start_r[w] = 1'b0;
        for (int n = 0; n < lat + 4; n++) begin
            glitch[w] = glitch_en[w] && (n % (s + 1) != s) && n < lat;
            if (done[w]) got = n;
            if (n < lat) chk({tag, " operands"}, int'({a_o[w], b_o[w]}), n / (s + 1));
            if (got >= 0) break;
            tick();
        end
        glitch[w] = 1'b0;
        chk({tag, " done edge"}, got, lat);
        if (got >= 0) begin
            chk({tag, " pass"}, int'(pass[w]), int'(e_pass));
            chk({tag, " fail_mask"}, int'(mask[w]), int'(e_mask));
            chk({tag, " first_fail_ab"}, int'(first[w]), int'(e_first));
            chk({tag, " busy in done"}, int'(busy[w]), 1);
`ifdef LOGIC_GATE_CHK_ERRCNT_EN
            chk({tag, " err_count"}, int'(err[w]), e_err);
`endif
            tick();
            chk({tag, " done pulse width"}, int'(done[w]), 0);
            chk({tag, " busy after"}, int'(busy[w]), 0);
            chk({tag, " pass held"}, int'(pass[w]), int'(e_pass));
        end
        if (e_err < 0) $display("unexpected error count request");
    endtask

    typedef struct {
        int         w;
        int         mode;
        bit         gl;
        bit         pass;
        logic [5:0] mask;
        logic [1:0] first;
        int         err;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int d1, d2, bsy9, idle19, m_first, m_err;
        logic [5:0] m_mask;
        for (int w = 0; w < 2; w++) begin
            start_r[w] = 1'b0; glitch[w] = 1'b0; glitch_en[w] = 1'b0; mode[w] = 0;
            for (int v = 0; v < 4; v++) corr[w][v] = '0;
        end
        tbl[0] = '{0, 0, 1'b0, 1'b1, 6'b000000, 2'b00, 0};
        tbl[1] = '{0, 1, 1'b0, 1'b0, 6'b000100, 2'b01, 2};
        tbl[2] = '{0, 2, 1'b0, 1'b0, 6'b011000, 2'b01, 4};
        tbl[3] = '{0, 4, 1'b0, 1'b0, 6'b000001, 2'b00, 3};
        tbl[4] = '{1, 0, 1'b1, 1'b1, 6'b000000, 2'b00, 0};
        tbl[5] = '{1, 1, 1'b0, 1'b0, 6'b000100, 2'b01, 2};
        tick();
        tick();
        for (int w = 0; w < 2; w++) begin
            chk("reset busy", int'(busy[w]), 0);
            chk("reset done", int'(done[w]), 0);
            chk("reset pass", int'(pass[w]), 0);
            chk("reset mask", int'(mask[w]), 0);
            chk("reset first", int'(first[w]), 0);
            chk("reset operands", int'({a_o[w], b_o[w]}), 0);
        end
        rst = 1'b0;
        repeat (3) tick();
        chk("idle without start", int'(busy[0]), 0);

        foreach (tbl[i]) begin
            mode[tbl[i].w] = tbl[i].mode;
            glitch_en[tbl[i].w] = tbl[i].gl;
            sweep(tbl[i].w, tbl[i].pass, tbl[i].mask, tbl[i].first, tbl[i].err, $sformatf("tbl%0d", i));
            mode[tbl[i].w] = 0;
            glitch_en[tbl[i].w] = 1'b0;
        end

        // reset in vector 2 DRIVE discards a failing partial result
        mode[0] = 1;
        start_r[0] = 1'b1;
        tick();
        start_r[0] = 1'b0;
        repeat (4) tick();
        chk("pre-rst operands", int'({a_o[0], b_o[0]}), 2);
        chk("pre-rst mask", int'(mask[0]), 6'b000100);
        rst = 1'b1;
        #1;
        chk("rst busy", int'(busy[0]), 0);
        chk("rst operands", int'({a_o[0], b_o[0]}), 0);
        chk("rst mask", int'(mask[0]), 0);
        chk("rst first", int'(first[0]), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst no done", int'(done[0]), 0);
        end
        rst = 1'b0;
        mode[0] = 0;
        tick();
        sweep(0, 1'b1, 6'b0, 2'b00, 0, "post-rst");

        // start re-pulsed while busy, then held through done
        d1 = -1; d2 = -1; bsy9 = -1; idle19 = -1;
        start_r[0] = 1'b1;
        tick();
        start_r[0] = 1'b0;
        for (int n = 0; n < 26; n++) begin
            start_r[0] = (n == 3) || (n >= 6 && n < 9);
            if (done[0] && d1 < 0) d1 = n;
            else if (done[0] && d2 < 0) d2 = n;
            if (n == 9) bsy9 = int'(busy[0]);
            if (n == 19) idle19 = int'(busy[0]);
            tick();
        end
        start_r[0] = 1'b0;
        chk("rearm first done", d1, 8);
        chk("rearm second done", d2, 17);
        chk("rearm busy continuous", bsy9, 1);
        chk("rearm idle after", idle19, 0);

        // random gate-bank corruption against a per-sweep model
        for (int i = 0; i < 16; i++) begin
            int w = i % 2;
            m_mask = '0; m_first = -1; m_err = 0;
            for (int v = 0; v < 4; v++) begin
                corr[w][v] = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
                if (corr[w][v] != 0 && m_first < 0) m_first = v;
                m_mask |= corr[w][v];
                m_err += $countones(corr[w][v]);
            end
            mode[w] = 3;
            sweep(w, m_mask == 0, m_mask, (m_first < 0) ? 2'b00 : 2'(m_first), m_err, $sformatf("rnd%0d", i));
            mode[w] = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
